// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg: size encodings, request-issue state type and alignment predicate
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Size 3 is treated as a word, so it shares the word alignment rule.
  function automatic logic mem_ale(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == MEM_SIZE_H) && addr_lo[0]) ||
           ((size >= MEM_SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_store_fmt.sv
// ============================================================================
// mem_store_fmt: byte enables and lane-replicated write data for a store
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_store_fmt
  import mem_pkg::*;
(
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_in,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_out
);

  always_comb begin
    wstrb     = 4'b1111;
    wdata_out = wdata_in;
    case (size)
      MEM_SIZE_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_out = {4{wdata_in[7:0]}};
      end
      MEM_SIZE_H: begin
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata_in[15:0]}};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_out = wdata_in;
      end
    endcase
    if (!wr) begin
      wstrb = 4'b0000;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_mem_req_issue.sv
// ============================================================================
// ex_mem_req_issue: EX-stage data_sram request issue, hold and in-flight count
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_mem_req_issue
  import mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_mem_op,
  input  logic        ex_mem_wr,
  input  logic [1:0]  ex_mem_size,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_wdata,
  input  logic        cancel,
  input  logic        mem_allowin,
  output logic        ex_ale,
  output logic        ex_mem_ready_go,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic [1:0]  outstanding
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  mem_state_e  state_q, state_d;
  logic        killed_q, killed_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;

  logic        issue;
  logic        accept;
  logic [1:0]  ex_size_norm;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_wdata;

  mem_store_fmt u_store_fmt (
    .wr        (ex_mem_wr),
    .size      (ex_size_norm),
    .addr_lo   (ex_mem_addr[1:0]),
    .wdata_in  (ex_mem_wdata),
    .wstrb     (fmt_wstrb),
    .wdata_out (fmt_wdata)
  );

  assign ex_size_norm = (ex_mem_size == 2'd3) ? MEM_SIZE_W : ex_mem_size;
  assign ex_ale       = ex_mem_op & mem_ale(ex_mem_size, ex_mem_addr[1:0]);
  // resetn gates issue so the request stays low for the whole reset interval.
  assign issue        = resetn & ex_mem_op & ~ex_ale & ~cancel & (outstanding_q < MAX_CNT);
  assign accept       = data_sram_req & data_sram_addr_ok;
  assign outstanding  = outstanding_q;

  always_comb begin
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'd0;
    data_sram_wstrb = 4'd0;
    data_sram_addr  = 32'd0;
    data_sram_wdata = 32'd0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          data_sram_req   = 1'b1;
          data_sram_wr    = ex_mem_wr;
          data_sram_size  = ex_size_norm;
          data_sram_wstrb = fmt_wstrb;
          data_sram_addr  = ex_mem_addr;
          data_sram_wdata = fmt_wdata;
        end
      end
      HOLD: begin
        data_sram_req   = 1'b1;
        data_sram_wr    = wr_q;
        data_sram_size  = size_q;
        data_sram_wstrb = wstrb_q;
        data_sram_addr  = addr_q;
        data_sram_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign ex_mem_ready_go = ~ex_mem_op | ex_ale | accept | (state_q == DONE);

  always_comb begin
    state_d       = state_q;
    killed_d      = killed_q;
    wr_d          = wr_q;
    size_d        = size_q;
    addr_d        = addr_q;
    wstrb_d       = wstrb_q;
    wdata_d       = wdata_q;
    outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, data_sram_data_ok};
    case (state_q)
      IDLE: begin
        if (data_sram_req) begin
          if (!data_sram_addr_ok) begin
            state_d = HOLD;
            wr_d    = data_sram_wr;
            size_d  = data_sram_size;
            addr_d  = data_sram_addr;
            wstrb_d = data_sram_wstrb;
            wdata_d = data_sram_wdata;
          end else if (!mem_allowin) begin
            state_d = DONE;
          end
        end
      end
      HOLD: begin
        killed_d = killed_q | cancel;
        // A killed request still completes on the bus but never reaches MEM.
        if (data_sram_addr_ok) begin
          killed_d = 1'b0;
          if (killed_q || cancel || mem_allowin) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (mem_allowin || cancel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      killed_q      <= 1'b0;
      outstanding_q <= 2'd0;
      wr_q          <= 1'b0;
      size_q        <= 2'd0;
      addr_q        <= 32'd0;
      wstrb_q       <= 4'd0;
      wdata_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      killed_q      <= killed_d;
      outstanding_q <= outstanding_d;
      wr_q          <= wr_d;
      size_q        <= size_d;
      addr_q        <= addr_d;
      wstrb_q       <= wstrb_d;
      wdata_q       <= wdata_d;
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
    !(data_sram_data_ok && (outstanding_q == 2'd0)));

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_req_issue.sv
// ============================================================================
// tb_ex_mem_req_issue: directed stimulus with a request-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_req_issue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_mem_op, ex_mem_wr, cancel, mem_allowin;
  logic [1:0]  ex_mem_size;
  logic [31:0] ex_mem_addr, ex_mem_wdata;
  logic        ex_ale, ex_mem_ready_go;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  outstanding;

  int checks   = 0;
  int failures = 0;

  ex_mem_req_issue #(.MAX_OUTSTANDING(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_mem_op         (ex_mem_op),
    .ex_mem_wr         (ex_mem_wr),
    .ex_mem_size       (ex_mem_size),
    .ex_mem_addr       (ex_mem_addr),
    .ex_mem_wdata      (ex_mem_wdata),
    .cancel            (cancel),
    .mem_allowin       (mem_allowin),
    .ex_ale            (ex_ale),
    .ex_mem_ready_go   (ex_mem_ready_go),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .outstanding       (outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: what the bus should see, derived from access width.
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_strb(input logic wr, input logic [1:0] size, input logic [31:0] addr);
    int n, a;
    n = nbytes(size);
    a = int'(addr[1:0]);
    if (!wr) return 4'd0;
    return 4'(((1 << n) - 1) << (a - (a % n)));
  endfunction

  function automatic logic [31:0] ref_data(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  logic        m_hold, m_done, m_killed;
  int          m_cnt;
  logic        h_wr;
  logic [1:0]  h_size;
  logic [3:0]  h_strb;
  logic [31:0] h_addr, h_data;

  always @(negedge clk) begin
    logic        e_ale, e_req, e_rdy, e_wr, was_killed;
    logic [1:0]  e_size;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_data;
    if (!resetn) begin
      m_hold = 1'b0; m_done = 1'b0; m_killed = 1'b0; m_cnt = 0;
    end else begin
      e_ale = ex_mem_op && ((int'(ex_mem_addr[1:0]) % nbytes(ex_mem_size)) != 0);
      e_wr = ex_mem_wr;
      e_size = (ex_mem_size == 2'd3) ? 2'd2 : ex_mem_size;
      e_addr = ex_mem_addr;
      e_strb = ref_strb(ex_mem_wr, ex_mem_size, ex_mem_addr);
      e_data = ref_data(ex_mem_size, ex_mem_wdata);
      if (m_hold) begin
        e_req = 1'b1;
        e_wr = h_wr; e_size = h_size; e_addr = h_addr; e_strb = h_strb; e_data = h_data;
      end else if (m_done) begin
        e_req = 1'b0;
      end else begin
        e_req = ex_mem_op && !e_ale && !cancel && (m_cnt < 2);
      end
      e_rdy = !ex_mem_op || e_ale || (e_req && data_sram_addr_ok) || m_done;
      chk("ale", 32'(ex_ale), 32'(e_ale));
      chk("req", 32'(data_sram_req), 32'(e_req));
      chk("ready_go", 32'(ex_mem_ready_go), 32'(e_rdy));
      chk("outstanding", 32'(outstanding), 32'(m_cnt));
      if (e_req) begin
        chk("wr", 32'(data_sram_wr), 32'(e_wr));
        chk("size", 32'(data_sram_size), 32'(e_size));
        chk("addr", data_sram_addr, e_addr);
        chk("wstrb", 32'(data_sram_wstrb), 32'(e_strb));
        chk("wdata", data_sram_wdata, e_data);
      end
      m_cnt = m_cnt + ((e_req && data_sram_addr_ok) ? 1 : 0) - (data_sram_data_ok ? 1 : 0);
      if (m_hold) begin
        was_killed = m_killed || cancel;
        m_killed = was_killed;
        if (data_sram_addr_ok) begin
          m_hold = 1'b0;
          m_killed = 1'b0;
          m_done = !was_killed && !mem_allowin;
        end
      end else if (m_done) begin
        if (mem_allowin || cancel) m_done = 1'b0;
      end else if (e_req) begin
        if (!data_sram_addr_ok) begin
          m_hold = 1'b1;
          h_wr = e_wr; h_size = e_size; h_addr = e_addr; h_strb = e_strb; h_data = e_data;
        end else if (!mem_allowin) begin
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic op, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd);
    ex_mem_op = op; ex_mem_wr = wr; ex_mem_size = size; ex_mem_addr = addr; ex_mem_wdata = wd;
  endtask

  task automatic bus(input logic aok, input logic dok, input logic allow, input logic cnl);
    data_sram_addr_ok = aok; data_sram_data_ok = dok; mem_allowin = allow; cancel = cnl;
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b1, 1'b1, 2'd2, 32'h1000, 32'h1);
    bus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    @(negedge clk);
    chk("rst_req", 32'(data_sram_req), 32'd0);
    chk("rst_rdy_op", 32'(ex_mem_ready_go), 32'd0);
    chk("rst_wstrb", 32'(data_sram_wstrb), 32'd0);
    chk("rst_out", 32'(outstanding), 32'd0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    bus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_rdy_idle", 32'(ex_mem_ready_go), 32'd1);
    chk("rst_addr", data_sram_addr, 32'd0);
    tick();
    resetn = 1'b1;

    // Word store, immediate accept
    drive(1'b1, 1'b1, 2'd2, 32'h1000, 32'hDEADBEEF);
    bus(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_req", 32'(data_sram_req), 32'd1);
    chk("t1_wstrb", 32'(data_sram_wstrb), 32'hF);
    chk("t1_rdy", 32'(ex_mem_ready_go), 32'd1);
    tick();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    bus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_out", 32'(outstanding), 32'd1);
    tick();
    bus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    bus(1'b0, 1'b0, 1'b0, 1'b0);

    // Byte store held 4 cycles while EX inputs wander
    drive(1'b1, 1'b1, 2'd0, 32'h1003, 32'h0000_00AB);
    bus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) drive(1'b1, 1'b1, 2'd2, 32'h2000, 32'h1234_5678);
      if (c == 3) data_sram_addr_ok = 1'b1;
      @(negedge clk);
      chk("t2_req", 32'(data_sram_req), 32'd1);
      chk("t2_addr", data_sram_addr, 32'h1003);
      chk("t2_wstrb", 32'(data_sram_wstrb), 32'b1000);
      chk("t2_wdata", data_sram_wdata, 32'hABAB_ABAB);
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    bus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    bus(1'b0, 1'b0, 1'b0, 1'b0);

    // Misaligned half load, and size 3 handled as word
    drive(1'b1, 1'b0, 2'd1, 32'h2001, 32'h0);
    bus(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_ale", 32'(ex_ale), 32'd1);
    chk("t3_req", 32'(data_sram_req), 32'd0);
    chk("t3_rdy", 32'(ex_mem_ready_go), 32'd1);
    tick();
    drive(1'b1, 1'b0, 2'd3, 32'h7002, 32'h0);
    @(negedge clk);
    chk("t3_out", 32'(outstanding), 32'd0);
    chk("t3_ale_sz3", 32'(ex_ale), 32'd1);
    tick();
    drive(1'b1, 1'b0, 2'd3, 32'h7004, 32'h0);
    @(negedge clk);
    chk("t3_size3", 32'(data_sram_size), 32'd2);
    tick();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    bus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Cancel while held: request stays up until accepted, then returns to idle
    drive(1'b1, 1'b0, 2'd2, 32'h3000, 32'h0);
    bus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cancel = 1'b1;
    @(negedge clk);
    chk("t4_req_c2", 32'(data_sram_req), 32'd1);
    tick();
    cancel = 1'b0;
    tick();
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    chk("t4_req_c4", 32'(data_sram_req), 32'd1);
    tick();
    bus(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_idle_rdy", 32'(ex_mem_ready_go), 32'd0);
    chk("t4_out", 32'(outstanding), 32'd1);
    tick();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    bus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    bus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_out_ret", 32'(outstanding), 32'd0);
    tick();

    // Throttle at two in flight
    drive(1'b1, 1'b0, 2'd2, 32'h4000, 32'h0);
    bus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    ex_mem_addr = 32'h4004;
    tick();
    ex_mem_addr = 32'h4008;
    @(negedge clk);
    chk("t5_req_full", 32'(data_sram_req), 32'd0);
    chk("t5_rdy_full", 32'(ex_mem_ready_go), 32'd0);
    tick();
    data_sram_data_ok = 1'b1;
    @(negedge clk);
    chk("t5_req_dok", 32'(data_sram_req), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_req_next", 32'(data_sram_req), 32'd1);
    tick();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5_out_same", 32'(outstanding), 32'd1);
    tick();
    bus(1'b0, 1'b0, 1'b0, 1'b0);

    // Accepted but MEM busy: DONE, no duplicate request
    drive(1'b1, 1'b1, 2'd1, 32'h5002, 32'h0000_BEEF);
    bus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_wstrb", 32'(data_sram_wstrb), 32'b1100);
    chk("t6_wdata", data_sram_wdata, 32'hBEEF_BEEF);
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t6_done_req", 32'(data_sram_req), 32'd0);
      chk("t6_done_rdy", 32'(ex_mem_ready_go), 32'd1);
      tick();
    end
    mem_allowin = 1'b1;
    @(negedge clk);
    chk("t6_out", 32'(outstanding), 32'd1);
    tick();
    drive(1'b1, 1'b0, 2'd2, 32'h5100, 32'h0);
    @(negedge clk);
    chk("t6_idle_req", 32'(data_sram_req), 32'd1);
    tick();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    bus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    bus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_out_zero", 32'(outstanding), 32'd0);
    tick();

    // Asynchronous reset while holding
    drive(1'b1, 1'b0, 2'd2, 32'h6000, 32'h0);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("t7_req_rst", 32'(data_sram_req), 32'd0);
    chk("t7_addr_rst", data_sram_addr, 32'd0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("t7_out", 32'(outstanding), 32'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
